uart_frame_gen: RTL and testbench

Parametrised UART frame generator with input byte FIFO. Serialises queued words onto a single line: start bit, LSB-first data, optional parity, then stop bits. Used to drive the CPU's serial input, both on-chip (self-test loopback) and in simulation. It replaces hand-timed serial stimulus with a cycle-exact, configurable source.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_frame_gen_if.sv | 30 +++
 rtl/uart_sync_fifo.sv | 51 +++++
 rtl/uart_frame_gen.sv | 172 +++++++++++++++++
 tb/tb_uart_frame_gen.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART frame generator and its receiver/bench.
// The BREAK state exists only when UART_BREAK_EN is defined.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
`ifdef UART_BREAK_EN
    StStop,
    StBreak
`else
    StStop
`endif
  } uart_state_e;

  // Cycles from the first start-bit cycle to the last stop-bit cycle inclusive.
  function automatic int unsigned frame_len(input int unsigned baud_div,
                                            input int unsigned data_bits,
                                            input int unsigned parity_mode,
                                            input int unsigned stop_bits);
    return baud_div * (1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits);
  endfunction

endpackage

// File: rtl/uart_frame_gen_if.sv
// Write-side and serial-side signals of uart_frame_gen.
// UART_BREAK_EN adds the brk_req request line.
interface uart_frame_gen_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned CNT_W     = 4
);
  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 full;
  logic                 overflow;
  logic [CNT_W-1:0]     fifo_count;
  logic                 busy;
  logic                 tx;
  logic                 frame_done;

`ifdef UART_BREAK_EN
  logic                 brk_req;

  modport master (output wr_en, wr_data, brk_req,
                  input  full, overflow, fifo_count, busy, tx, frame_done);
  modport slave  (input  wr_en, wr_data, brk_req,
                  output full, overflow, fifo_count, busy, tx, frame_done);
`else
  modport master (output wr_en, wr_data,
                  input  full, overflow, fifo_count, busy, tx, frame_done);
  modport slave  (input  wr_en, wr_data,
                  output full, overflow, fifo_count, busy, tx, frame_done);
`endif

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock word FIFO feeding the frame generator.
// A push while full is ignored even if a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_W-1:0]     count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]      wptr_q, rptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 do_push, do_pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_frame_gen.sv
// UART frame generator: FIFO-fed, LSB-first serialiser with optional parity and 1-2 stop bits.
// Defining UART_BREAK_EN adds brk_req and a BREAK state holding tx low for two frame times.
module uart_frame_gen
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV    = 16,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input logic              sysclk,
  input logic              reset,
  uart_frame_gen_if.slave  bus
);

  localparam int unsigned       BaudW    = $clog2(BAUD_DIV);
  localparam int unsigned       BitW     = $clog2(DATA_BITS);
  localparam logic [BaudW-1:0]  BaudLast = BaudW'(BAUD_DIV - 1);
  localparam logic [BitW-1:0]   DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0]   StopLast = BitW'(STOP_BITS - 1);

  uart_state_e          state_q;
  logic [BaudW-1:0]     baud_cnt_q;
  logic [BitW-1:0]      bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 frame_done_q;
  logic                 overflow_q;

  logic [DATA_BITS-1:0] head;
  logic                 full, empty;
  logic [CNT_W-1:0]     count;
  logic                 stop_end, launch, pop;

  assign stop_end = (state_q == StStop) && (baud_cnt_q == '0) && (bit_idx_q == StopLast);
  assign launch   = (state_q == StIdle) || stop_end;

`ifdef UART_BREAK_EN
  localparam int unsigned      BrkLen  = 2 * frame_len(BAUD_DIV, DATA_BITS, PARITY_MODE, STOP_BITS);
  localparam int unsigned      BrkW    = $clog2(BrkLen);
  localparam logic [BrkW-1:0]  BrkLast = BrkW'(BrkLen - 1);

  logic [BrkW-1:0] brk_cnt_q;
  logic            brk_go;

  // A break request outranks a pending word at every frame boundary.
  assign brk_go = launch && bus.brk_req;
  assign pop    = launch && !empty && !brk_go;
`else
  assign pop    = launch && !empty;
`endif

  uart_sync_fifo #(
    .DATA_BITS (DATA_BITS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W)
  ) u_fifo (
    .clk  (sysclk),
    .rst  (reset),
    .push (bus.wr_en),
    .pop  (pop),
    .wdata(bus.wr_data),
    .rdata(head),
    .full (full),
    .empty(empty),
    .count(count)
  );

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      baud_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef UART_BREAK_EN
      brk_cnt_q    <= '0;
`endif
    end else begin
      overflow_q   <= bus.wr_en && full;
      frame_done_q <= (state_q == StStop) && (bit_idx_q == StopLast) &&
                      (baud_cnt_q == BaudW'(1));
`ifdef UART_BREAK_EN
      if (brk_go) begin
        state_q   <= StBreak;
        brk_cnt_q <= BrkLast;
        tx_q      <= 1'b0;
      end else
`endif
      if (pop) begin
        state_q    <= StStart;
        shift_q    <= head;
        par_q      <= (^head) ^ (PARITY_MODE == PARITY_ODD);
        baud_cnt_q <= BaudLast;
        tx_q       <= 1'b0;
      end else if ((state_q != StIdle) && (baud_cnt_q != '0)
`ifdef UART_BREAK_EN
                   && (state_q != StBreak)
`endif
                  ) begin
        baud_cnt_q <= baud_cnt_q - 1'b1;
      end else begin
        unique case (state_q)
          StIdle: ;
          StStart: begin
            state_q    <= StData;
            tx_q       <= shift_q[0];
            shift_q    <= shift_q >> 1;
            bit_idx_q  <= '0;
            baud_cnt_q <= BaudLast;
          end
          StData: begin
            baud_cnt_q <= BaudLast;
            if (bit_idx_q == DataLast) begin
              bit_idx_q <= '0;
              if (PARITY_MODE != PARITY_NONE) begin
                state_q <= StParity;
                tx_q    <= par_q;
              end else begin
                state_q <= StStop;
                tx_q    <= 1'b1;
              end
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
          StParity: begin
            state_q    <= StStop;
            tx_q       <= 1'b1;
            bit_idx_q  <= '0;
            baud_cnt_q <= BaudLast;
          end
          StStop: begin
            if (bit_idx_q == StopLast) begin
              state_q <= StIdle;
            end else begin
              bit_idx_q  <= bit_idx_q + 1'b1;
              baud_cnt_q <= BaudLast;
            end
          end
`ifdef UART_BREAK_EN
          StBreak: begin
            if (brk_cnt_q != '0) begin
              brk_cnt_q <= brk_cnt_q - 1'b1;
            end else begin
              state_q <= StIdle;
              tx_q    <= 1'b1;
            end
          end
`endif
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.full       = full;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = count;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_frame_gen.sv
// Directed bench for uart_frame_gen: four configurations at BAUD_DIV=4 checked against a
// bit-level frame model; the break scenario runs only when UART_BREAK_EN is defined.
module tb_uart_frame_gen;
  import uart_pkg::*;

  localparam int unsigned BD = 4;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 sysclk = ~sysclk;

  uart_frame_gen_if #(.DATA_BITS(8), .CNT_W(4)) if_a ();
  uart_frame_gen_if #(.DATA_BITS(8), .CNT_W(4)) if_e ();
  uart_frame_gen_if #(.DATA_BITS(8), .CNT_W(4)) if_o ();
  uart_frame_gen_if #(.DATA_BITS(7), .CNT_W(4)) if_s ();

  uart_frame_gen #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1),
                   .FIFO_DEPTH(8)) dut_a (.sysclk(sysclk), .reset(reset), .bus(if_a));
  uart_frame_gen #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1),
                   .FIFO_DEPTH(8)) dut_e (.sysclk(sysclk), .reset(reset), .bus(if_e));
  uart_frame_gen #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1),
                   .FIFO_DEPTH(8)) dut_o (.sysclk(sysclk), .reset(reset), .bus(if_o));
  uart_frame_gen #(.BAUD_DIV(BD), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2),
                   .FIFO_DEPTH(8)) dut_s (.sysclk(sysclk), .reset(reset), .bus(if_s));

  // Expected line level c cycles after the start bit began (idle high after the frame).
  function automatic logic exp_tx(input int c, input logic [8:0] d, input int nb,
                                  input int pm);
    int b;
    b = c / int'(BD);
    if (b == 0) return 1'b0;
    if (b <= nb) return d[b-1];
    if (pm != 0 && b == nb + 1) return (^d) ^ (pm == 2);
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  logic [63:0] cap_tx  [4];
  logic [63:0] cap_bsy [4];
  logic [63:0] cap_fd  [4];
  logic [63:0] e_tx, e_bsy, e_fd;
  logic [8:0]  wd  [4] = '{9'h0A5, 9'h007, 9'h007, 9'h055};
  int          nbs [4] = '{8, 8, 8, 7};
  int          pms [4] = '{0, 1, 2, 1};
  int          nss [4] = '{1, 1, 1, 2};

  initial begin
    int fl, c, tx_bad, gap, fd_cnt, hi_bad;
    if_a.wr_en = 1'b0; if_a.wr_data = '0;
    if_e.wr_en = 1'b0; if_e.wr_data = '0;
    if_o.wr_en = 1'b0; if_o.wr_data = '0;
    if_s.wr_en = 1'b0; if_s.wr_data = '0;
`ifdef UART_BREAK_EN
    if_a.brk_req = 1'b0; if_e.brk_req = 1'b0; if_o.brk_req = 1'b0; if_s.brk_req = 1'b0;
`endif

    // Reset state
    #12;
    chk("rst_tx", if_a.tx, 1);
    chk("rst_busy", if_a.busy, 0);
    chk("rst_full", if_a.full, 0);
    chk("rst_ovf", if_a.overflow, 0);
    chk("rst_fd", if_a.frame_done, 0);
    chk("rst_cnt", if_a.fifo_count, 0);
    chk("rst_tx_s", if_s.tx, 1);
    @(negedge sysclk);
    reset = 1'b0;
    tick();
    tick();

    // Single frames on all four configurations at once
    if_a.wr_en = 1'b1; if_a.wr_data = 8'hA5;
    if_e.wr_en = 1'b1; if_e.wr_data = 8'h07;
    if_o.wr_en = 1'b1; if_o.wr_data = 8'h07;
    if_s.wr_en = 1'b1; if_s.wr_data = 7'h55;
    tick();
    if_a.wr_en = 1'b0; if_e.wr_en = 1'b0; if_o.wr_en = 1'b0; if_s.wr_en = 1'b0;
    chk("lat_tx_idle", if_a.tx, 1);
    chk("lat_cnt1", if_a.fifo_count, 1);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (i == 0) chk("lat_cnt0", if_a.fifo_count, 0);
      cap_tx[0][i] = if_a.tx; cap_bsy[0][i] = if_a.busy; cap_fd[0][i] = if_a.frame_done;
      cap_tx[1][i] = if_e.tx; cap_bsy[1][i] = if_e.busy; cap_fd[1][i] = if_e.frame_done;
      cap_tx[2][i] = if_o.tx; cap_bsy[2][i] = if_o.busy; cap_fd[2][i] = if_o.frame_done;
      cap_tx[3][i] = if_s.tx; cap_bsy[3][i] = if_s.busy; cap_fd[3][i] = if_s.frame_done;
    end
    for (int k = 0; k < 4; k++) begin
      fl = int'(frame_len(BD, nbs[k], pms[k], nss[k]));
      for (int i = 0; i < 60; i++) begin
        e_tx[i]  = exp_tx(i, wd[k], nbs[k], pms[k]);
        e_bsy[i] = (i < fl);
        e_fd[i]  = (i == fl - 1);
      end
      chk($sformatf("frame%0d_tx", k), cap_tx[k], e_tx);
      chk($sformatf("frame%0d_busy", k), cap_bsy[k], e_bsy);
      chk($sformatf("frame%0d_done", k), cap_fd[k], e_fd);
    end

    // Back-to-back frames, full and overflow on the 8N1 instance
    tx_bad = 0; gap = 0; fd_cnt = 0;
    for (int t = 0; t <= 362; t++) begin
      if (t < 10) begin
        if_a.wr_en = 1'b1; if_a.wr_data = 8'(8'h30 + t);
      end else begin
        if_a.wr_en = 1'b0;
      end
      tick();
      c = t - 1;
      if (t == 7) chk("b2b_not_full_8w", if_a.full, 0);
      if (t == 8) chk("b2b_full_9w", if_a.full, 1);
      if (t == 8) chk("b2b_cnt_full", if_a.fifo_count, 8);
      if (t == 9) chk("b2b_ovf", if_a.overflow, 1);
      if (t == 10) chk("b2b_ovf_pulse", if_a.overflow, 0);
      if (c > 0 && c < 360 && c % 40 == 0) begin
        chk($sformatf("b2b_cnt_at_start%0d", c / 40), if_a.fifo_count, 8 - c / 40);
      end
      if (c >= 0 && c < 360) begin
        if (if_a.tx !== exp_tx(c % 40, 9'(8'h30 + c / 40), 8, 0)) tx_bad++;
        if (if_a.busy !== 1'b1) gap++;
        if (if_a.frame_done === 1'b1) fd_cnt++;
      end
      if (c == 360) chk("b2b_idle_after", if_a.busy, 0);
    end
    chk("b2b_tx_stream", tx_bad, 0);
    chk("b2b_no_gap", gap, 0);
    chk("b2b_done_cnt", fd_cnt, 9);

    // Reset during data bit 3
    if_a.wr_en = 1'b1; if_a.wr_data = 8'h00;
    tick();
    if_a.wr_data = 8'h11;
    tick();
    if_a.wr_en = 1'b0;
    repeat (17) tick();
    chk("mid_tx_low", if_a.tx, 0);
    chk("mid_cnt", if_a.fifo_count, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_tx", if_a.tx, 1);
    chk("mid_rst_cnt", if_a.fifo_count, 0);
    chk("mid_rst_busy", if_a.busy, 0);
    @(negedge sysclk);
    reset = 1'b0;
    hi_bad = 0;
    repeat (100) begin
      tick();
      if (if_a.tx !== 1'b1 || if_a.busy !== 1'b0) hi_bad++;
    end
    chk("mid_stay_idle", hi_bad, 0);

`ifdef UART_BREAK_EN
    // Break request outranks a queued word
    if_a.wr_en = 1'b1; if_a.wr_data = 8'h5A;
    tick();
    if_a.wr_en = 1'b0; if_a.brk_req = 1'b1;
    tx_bad = 0; hi_bad = 0;
    for (int i = 0; i < 125; i++) begin
      tick();
      if_a.brk_req = 1'b0;
      if (i < 80 && (if_a.tx !== 1'b0 || if_a.busy !== 1'b1)) hi_bad++;
      if (i == 40) chk("brk_fifo_kept", if_a.fifo_count, 1);
      if (i == 80) chk("brk_end_tx", if_a.tx, 1);
      if (i == 80) chk("brk_end_idle", if_a.busy, 0);
      if (i == 81) chk("brk_pop", if_a.fifo_count, 0);
      if (i >= 81 && if_a.tx !== exp_tx(i - 81, 9'h05A, 8, 0)) tx_bad++;
    end
    chk("brk_low_80", hi_bad, 0);
    chk("brk_then_frame", tx_bad, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
